// File: rtl/step_button_conditioner.sv
// Per-channel input conditioner: 2-flop synchronizer, debounce filter, rising-edge
// step pulse and hold-to-repeat FSM, producing clean single-cycle step pulses.
module step_button_conditioner #(
  parameter int CHANNELS        = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16,
  parameter int CNT_W           = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] step_pulse,
  output logic [CHANNELS-1:0] held
);

  typedef enum logic [1:0] {IDLE, HOLD_DELAY, HOLD_REPEAT} state_t;

  localparam bit              REPEAT_EN = (REPEAT_DELAY > 0);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_EN ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;

  // The synchronizer keeps sampling even while ena is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] rcnt;
    logic [CNT_W-1:0] rcnt_nx;
    logic             level;
    logic             pulse_q;
    logic             pulse_nx;
    logic             db_done;
    logic             rise_acc;
    logic             fall_acc;
    state_t           state;
    state_t           state_nx;

    assign db_done  = (s2[g] != level) && (db_cnt == DB_LAST);
    assign rise_acc = db_done && s2[g];
    assign fall_acc = db_done && !s2[g];

    always_ff @(posedge clk) begin
      if (rst) begin
        db_cnt <= '0;
        level  <= 1'b0;
      end else if (ena) begin
        if (s2[g] == level) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          level  <= s2[g];
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + CNT_ONE;
        end
      end
    end

    // Release wins over a repeat that falls due in the same cycle.
    always_comb begin
      state_nx = state;
      rcnt_nx  = rcnt;
      pulse_nx = 1'b0;
      case (state)
        IDLE: begin
          if (rise_acc) begin
            pulse_nx = 1'b1;
            rcnt_nx  = '0;
            state_nx = HOLD_DELAY;
          end
        end
        HOLD_DELAY: begin
          if (fall_acc) begin
            rcnt_nx  = '0;
            state_nx = IDLE;
          end else if (REPEAT_EN) begin
            if (rcnt == RD_LAST) begin
              pulse_nx = 1'b1;
              rcnt_nx  = '0;
              state_nx = HOLD_REPEAT;
            end else begin
              rcnt_nx = rcnt + CNT_ONE;
            end
          end
        end
        HOLD_REPEAT: begin
          if (fall_acc) begin
            rcnt_nx  = '0;
            state_nx = IDLE;
          end else if (rcnt == RP_LAST) begin
            pulse_nx = 1'b1;
            rcnt_nx  = '0;
          end else begin
            rcnt_nx = rcnt + CNT_ONE;
          end
        end
        default: begin
          rcnt_nx  = '0;
          state_nx = IDLE;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state   <= IDLE;
        rcnt    <= '0;
        pulse_q <= 1'b0;
      end else if (ena) begin
        state   <= state_nx;
        rcnt    <= rcnt_nx;
        pulse_q <= pulse_nx;
      end else begin
        pulse_q <= 1'b0;
      end
    end

    assign btn_level[g]  = level;
    assign step_pulse[g] = pulse_q && ena;
    assign held[g]       = (state != IDLE);
  end

endmodule

// File: tb/tb_step_button_conditioner.sv
// Directed bench for step_button_conditioner: one instance without auto-repeat (D=4)
// and one with fast auto-repeat (D=2, delay 8, period 3).
module tb_step_button_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, ena_a, rst_b, ena_b;
  logic [1:0] raw_a, level_a, pulse_a, held_a;
  logic [1:0] raw_b, level_b, pulse_b, held_b;
  int checks = 0;
  int errors = 0;

  step_button_conditioner #(
    .CHANNELS(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(16), .CNT_W(8)
  ) dut_a (
    .clk(clk), .rst(rst_a), .ena(ena_a), .btn_raw(raw_a),
    .btn_level(level_a), .step_pulse(pulse_a), .held(held_a)
  );

  step_button_conditioner #(
    .CHANNELS(2), .DEBOUNCE_CYCLES(2), .REPEAT_DELAY(8), .REPEAT_PERIOD(3), .CNT_W(8)
  ) dut_b (
    .clk(clk), .rst(rst_b), .ena(ena_b), .btn_raw(raw_b),
    .btn_level(level_b), .step_pulse(pulse_b), .held(held_b)
  );

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1; ena_a = 1'b1; ena_b = 1'b1;
    raw_a = 2'b11; raw_b = 2'b11;
    repeat (8) tick();
    checks++;
    if ({level_a, pulse_a, held_a} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_a got %b expected %b", {level_a, pulse_a, held_a}, 6'b0);
    end
    checks++;
    if ({level_b, pulse_b, held_b} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_b got %b expected %b", {level_b, pulse_b, held_b}, 6'b0);
    end
    raw_a = 2'b00; raw_b = 2'b00;
    repeat (3) tick();
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
  endtask

  // Tick k=1 is the first edge sampling the new raw value; acceptance at k=E+1+D=6.
  task automatic test_press_release;
    logic el, ep;
    for (int k = 1; k <= 20; k++) begin
      raw_a[0] = 1'b1;
      tick();
      el = (k >= 6);
      ep = (k == 6);
      checks++;
      if ({level_a, pulse_a, held_a} !== {1'b0, el, 1'b0, ep, 1'b0, el}) begin
        errors++;
        $display("[TB] FAIL press k=%0d got %b expected %b", k,
                 {level_a, pulse_a, held_a}, {1'b0, el, 1'b0, ep, 1'b0, el});
      end
    end
    for (int k = 1; k <= 10; k++) begin
      raw_a[0] = 1'b0;
      tick();
      el = (k < 6);
      checks++;
      if ({level_a, pulse_a, held_a} !== {1'b0, el, 2'b00, 1'b0, el}) begin
        errors++;
        $display("[TB] FAIL release k=%0d got %b expected %b", k,
                 {level_a, pulse_a, held_a}, {1'b0, el, 2'b00, 1'b0, el});
      end
    end
  endtask

  // Raw pattern 1,1,1,0,0,1,1,0 then stable high from index 8; debounce at edge k
  // sees raw index k-3, so the stable run is accepted at k=14.
  task automatic test_bounce;
    logic [8:0] seq;
    logic el, ep;
    seq = 9'b1_0110_0111;
    for (int k = 1; k <= 20; k++) begin
      raw_a[0] = (k <= 9) ? seq[k-1] : 1'b1;
      tick();
      el = (k >= 14);
      ep = (k == 14);
      checks++;
      if ({level_a[0], pulse_a[0]} !== {el, ep}) begin
        errors++;
        $display("[TB] FAIL bounce k=%0d got %b expected %b", k,
                 {level_a[0], pulse_a[0]}, {el, ep});
      end
    end
    raw_a[0] = 1'b0;
    repeat (10) tick();
  endtask

  // dut_b: acceptance A at k=4, repeats at 12,15,18,21,24; release accepted at k=25.
  task automatic test_repeat;
    logic ep, eh;
    for (int k = 1; k <= 32; k++) begin
      raw_b[0] = (k <= 21);
      tick();
      ep = (k == 4) || (k >= 12 && k <= 24 && (k - 12) % 3 == 0);
      eh = (k >= 4 && k < 25);
      checks++;
      if ({level_b, pulse_b, held_b} !== {1'b0, eh, 1'b0, ep, 1'b0, eh}) begin
        errors++;
        $display("[TB] FAIL repeat k=%0d got %b expected %b", k,
                 {level_b, pulse_b, held_b}, {1'b0, eh, 1'b0, ep, 1'b0, eh});
      end
    end
  endtask

  // Release accepted at k=27, exactly when the next repeat falls due.
  task automatic test_release_collision;
    logic ep, eh;
    for (int k = 1; k <= 32; k++) begin
      raw_b[0] = (k <= 23);
      tick();
      ep = (k == 4) || (k >= 12 && k <= 24 && (k - 12) % 3 == 0);
      eh = (k >= 4 && k < 27);
      checks++;
      if ({pulse_b[0], held_b[0], level_b[0]} !== {ep, eh, eh}) begin
        errors++;
        $display("[TB] FAIL collision k=%0d got %b expected %b", k,
                 {pulse_b[0], held_b[0], level_b[0]}, {ep, eh, eh});
      end
    end
  endtask

  // Both channels pressed together; ch1 released so its fall is accepted at k=19.
  task automatic test_back_to_back;
    logic ep0, eh0, ep1, eh1;
    for (int k = 1; k <= 30; k++) begin
      raw_b = {1'(k <= 15), 1'(k <= 21)};
      tick();
      ep0 = (k == 4) || (k >= 12 && k <= 24 && (k - 12) % 3 == 0);
      eh0 = (k >= 4 && k < 25);
      ep1 = ep0 && (k <= 18);
      eh1 = (k >= 4 && k < 19);
      checks++;
      if ({pulse_b, held_b} !== {ep1, ep0, eh1, eh0}) begin
        errors++;
        $display("[TB] FAIL two_chan k=%0d got %b expected %b", k,
                 {pulse_b, held_b}, {ep1, ep0, eh1, eh0});
      end
    end
  endtask

  // ena low for edges 7..11 in HOLD_DELAY pushes the first repeat from 12 to 17.
  task automatic test_enable_freeze;
    logic ep;
    for (int k = 1; k <= 24; k++) begin
      raw_b[0] = 1'b1;
      ena_b = !(k >= 7 && k <= 11);
      tick();
      ep = (k == 4) || (k == 17) || (k == 20) || (k == 23);
      checks++;
      if ({pulse_b[0], held_b[0], level_b[0]} !== {ep, 1'(k >= 4), 1'(k >= 4)}) begin
        errors++;
        $display("[TB] FAIL ena k=%0d got %b expected %b", k,
                 {pulse_b[0], held_b[0], level_b[0]}, {ep, 1'(k >= 4), 1'(k >= 4)});
      end
    end
    ena_b = 1'b1;
    raw_b[0] = 1'b0;
    repeat (8) tick();
    checks++;
    if ({held_b, level_b} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL ena_release got %b expected %b", {held_b, level_b}, 4'b0);
    end
  endtask

  // Reset at edge 16 in HOLD_REPEAT; input still high, re-accepted at 16+D+2=20.
  task automatic test_reset_mid_hold;
    logic ep, eh;
    for (int k = 1; k <= 27; k++) begin
      raw_b[0] = 1'b1;
      rst_b = (k == 16);
      tick();
      if (k < 16) begin
        ep = (k == 4) || (k == 12) || (k == 15);
        eh = (k >= 4);
      end else begin
        ep = (k == 20);
        eh = (k >= 20);
      end
      checks++;
      if ({pulse_b[0], held_b[0], level_b[0]} !== {ep, eh, eh}) begin
        errors++;
        $display("[TB] FAIL rst_hold k=%0d got %b expected %b", k,
                 {pulse_b[0], held_b[0], level_b[0]}, {ep, eh, eh});
      end
    end
    rst_b = 1'b0;
    raw_b[0] = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_repeat();
    test_release_collision();
    test_back_to_back();
    test_enable_freeze();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
